mttkrp_shard_scheduler: RTL



---
 rtl/mttkrp_sched_pkg.sv | 16 +
 rtl/mttkrp_shard_scheduler_if.sv | 38 +++
 rtl/mttkrp_rr_pick.sv | 33 +++
 rtl/mttkrp_shard_scheduler.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mttkrp_sched_pkg.sv
// Shared types for the MTTKRP shard scheduler.
// FSM states and per-unit in-flight occupancy.
package mttkrp_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEGIN,
    S_STREAM,
    S_END
  } state_e;

  typedef logic [1:0] inflight_t;

  localparam inflight_t INFLIGHT_MAX = 2'd2;

endpackage

// File: rtl/mttkrp_shard_scheduler_if.sv
// Shard descriptor, element stream and compute-unit bus.
// master = reader/unit-array side, slave = scheduler side.
interface mttkrp_shard_scheduler_if #(
  parameter int NUM_COMPUTE_UNITS = 4,
  parameter int TENSOR_WIDTH      = 128,
  parameter int SHARD_LEN_WIDTH   = 16
);
  logic                         shard_desc_valid;
  logic                         shard_desc_ready;
  logic [SHARD_LEN_WIDTH-1:0]   shard_desc_len;
  logic                         in_tensor_en;
  logic                         in_tensor_ready;
  logic [TENSOR_WIDTH-1:0]      in_tensor_element;
  logic [NUM_COMPUTE_UNITS-1:0] cu_begining_of_shard;
  logic [NUM_COMPUTE_UNITS-1:0] cu_end_of_shard;
  logic [NUM_COMPUTE_UNITS-1:0] cu_tensor_element_en;
  logic [TENSOR_WIDTH-1:0]      cu_tensor_element;
  logic [NUM_COMPUTE_UNITS-1:0] cu_ready_receive_tensor;
  logic [NUM_COMPUTE_UNITS-1:0] cu_op_done_ack;

  modport master (
    output shard_desc_valid, shard_desc_len,
    output in_tensor_en, in_tensor_element,
    output cu_ready_receive_tensor, cu_op_done_ack,
    input  shard_desc_ready, in_tensor_ready,
    input  cu_begining_of_shard, cu_end_of_shard,
    input  cu_tensor_element_en, cu_tensor_element
  );

  modport slave (
    input  shard_desc_valid, shard_desc_len,
    input  in_tensor_en, in_tensor_element,
    input  cu_ready_receive_tensor, cu_op_done_ack,
    output shard_desc_ready, in_tensor_ready,
    output cu_begining_of_shard, cu_end_of_shard,
    output cu_tensor_element_en, cu_tensor_element
  );
endinterface

// File: rtl/mttkrp_rr_pick.sv
// Round-robin picker: first eligible unit after last_sel.
// Purely combinational; grant is one-hot or all zero.
module mttkrp_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] last_sel,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic          found;
  int            cand;
  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    j     = '0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last_sel) + i;
      if (cand >= N) cand = cand - N;
      j = IW'(cand);
      if (!found && elig[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/mttkrp_shard_scheduler.sv
// Dispatches shards round-robin to mirrored MTTKRP units,
// tracking per-unit in-flight shards from done acks.
module mttkrp_shard_scheduler
  import mttkrp_sched_pkg::*;
#(
  parameter int NUM_COMPUTE_UNITS = 4,
  parameter int TENSOR_WIDTH      = 128,
  parameter int SHARD_LEN_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  mttkrp_shard_scheduler_if.slave bus,
  output logic        idle,
  output logic [31:0] dispatched_count,
  output logic        err_spurious_done
);
  localparam int N  = NUM_COMPUTE_UNITS;
  localparam int IW = $clog2(N);
  localparam int TW = TENSOR_WIDTH;
  localparam int LW = SHARD_LEN_WIDTH;

  state_e        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] last_q, last_d;
  logic [N-1:0]  bos_q, bos_d;
  logic [N-1:0]  eos_q, eos_d;
  logic [N-1:0]  en_q, en_d;
  logic [TW-1:0] elem_q, elem_d;
  logic [31:0]   disp_q, disp_d;
  logic          err_q, err_d;
  inflight_t     infl_q [N];
  inflight_t     infl_d [N];

  logic [N-1:0]  elig, pick_oh, sel_oh;
  logic [IW-1:0] pick_idx;
  logic          desc_hs, elem_hs, inc, dec;

  mttkrp_rr_pick #(.N(N), .IW(IW)) u_pick (
    .elig     (elig),
    .last_sel (last_q),
    .grant    (pick_oh),
    .idx      (pick_idx)
  );

  assign sel_oh = {{(N-1){1'b0}}, 1'b1} << sel_q;

  always_comb begin
    idle = (state_q == S_IDLE);
    for (int u = 0; u < N; u++) begin
      elig[u] = infl_q[u] < INFLIGHT_MAX;
      if (infl_q[u] != '0) idle = 1'b0;
    end
  end

  // Hold off a new descriptor during the end-pulse cycle.
  assign bus.shard_desc_ready = ~rst & (state_q == S_IDLE)
                              & (|elig) & ~(|eos_q);
  assign bus.in_tensor_ready  = (state_q == S_STREAM)
                              & bus.cu_ready_receive_tensor[sel_q]
                              & (rem_q != '0);

  assign desc_hs = bus.shard_desc_valid & bus.shard_desc_ready;
  assign elem_hs = bus.in_tensor_en & bus.in_tensor_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    last_d  = last_q;
    bos_d   = '0;
    eos_d   = '0;
    en_d    = '0;
    elem_d  = elem_q;
    disp_d  = disp_q;
    err_d   = err_q;
    infl_d  = infl_q;
    inc     = 1'b0;
    dec     = 1'b0;
    unique case (state_q)
      S_IDLE: if (desc_hs) begin
        rem_d   = bus.shard_desc_len;
        sel_d   = pick_idx;
        bos_d   = pick_oh;
        state_d = S_BEGIN;
      end
      S_BEGIN: begin
        // Zero-length shards end right after the begin pulse.
        if (rem_q == '0) begin
          eos_d   = sel_oh;
          state_d = S_END;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_STREAM: if (elem_hs) begin
        en_d   = sel_oh;
        elem_d = bus.in_tensor_element;
        rem_d  = rem_q - LW'(1);
        if (rem_q == LW'(1)) state_d = S_END;
      end
      S_END: begin
        if (!(|eos_q)) eos_d = sel_oh;
        state_d = S_IDLE;
      end
    endcase
    if (|eos_d) begin
      disp_d = disp_q + 32'd1;
      last_d = sel_q;
    end
    for (int u = 0; u < N; u++) begin
      inc = (state_q == S_BEGIN) && (sel_q == IW'(u));
      dec = bus.cu_op_done_ack[u];
      if (dec && infl_q[u] == '0) begin
        err_d = 1'b1;
        if (inc) infl_d[u] = 2'd1;
      end else if (inc && !dec) begin
        infl_d[u] = infl_q[u] + 2'd1;
      end else if (dec && !inc) begin
        infl_d[u] = infl_q[u] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      sel_q   <= '0;
      last_q  <= IW'(N - 1);
      bos_q   <= '0;
      eos_q   <= '0;
      en_q    <= '0;
      elem_q  <= '0;
      disp_q  <= '0;
      err_q   <= 1'b0;
      for (int u = 0; u < N; u++) infl_q[u] <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      bos_q   <= bos_d;
      eos_q   <= eos_d;
      en_q    <= en_d;
      elem_q  <= elem_d;
      disp_q  <= disp_d;
      err_q   <= err_d;
      infl_q  <= infl_d;
    end
  end

  assign bus.cu_begining_of_shard = bos_q;
  assign bus.cu_end_of_shard      = eos_q;
  assign bus.cu_tensor_element_en = en_q;
  assign bus.cu_tensor_element    = elem_q;
  assign dispatched_count         = disp_q;
  assign err_spurious_done        = err_q;
endmodule
